// File: rtl/risc_v_pkg.sv
// Shared encodings for the RV32I multi-cycle controller:
// opcodes, datapath select codes, control bundle and FSM states.
package risc_v_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_REG   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADR,
        ST_MEM_READ,
        ST_MEM_WB,
        ST_MEM_WRITE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_ALU_WB,
        ST_BRANCH,
        ST_JAL,
        ST_JALR,
        ST_JALR_LINK,
        ST_LUI
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [2:0] imm_src;
        logic [1:0] result_src;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps func3/func7 to an ALU operation; flags func3 values
// that have no supported R/I-type meaning (shifts).
module mc_alu_decoder
    import risc_v_pkg::*;
(
    input  logic [2:0] func3,
    input  logic       func7,
    input  logic       is_rtype,
    output logic [2:0] alu_control,
    output logic       func_legal
);

    always_comb begin
        alu_control = ALU_ADD;
        func_legal  = 1'b1;
        unique case (func3)
            3'b000:  alu_control = (is_rtype && func7) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_control = ALU_AND;
            3'b110:  alu_control = ALU_OR;
            3'b100:  alu_control = ALU_XOR;
            3'b010:  alu_control = ALU_SLT;
            3'b011:  alu_control = ALU_SLTU;
            default: func_legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/risc_v_multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch through write-back
// and drives all datapath selects and write enables.
module risc_v_multicycle_controller
    import risc_v_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       func7,
    input  logic       zero,
    input  logic       b31,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [2:0] imm_src,
    output logic [1:0] result_src,
    output logic       illegal_op,
    output logic       instr_done
);

    state_e     state_q;
    state_e     state_d;
    ctrl_t      ctrl;
    logic [2:0] dec_alu;
    logic       func_ok;
    logic       illegal;
    logic       taken;

    mc_alu_decoder u_alu_dec (
        .func3      (func3),
        .func7      (func7),
        .is_rtype   (op == OP_RTYPE),
        .alu_control(dec_alu),
        .func_legal (func_ok)
    );

    always_comb begin
        illegal = 1'b1;
        case (op)
            OP_LOAD, OP_STORE, OP_JAL, OP_LUI: illegal = 1'b0;
            OP_RTYPE, OP_ITYPE: illegal = !func_ok;
            OP_BRANCH: illegal = func3[1];
            OP_JALR:   illegal = (func3 != 3'b000);
            default:   illegal = 1'b1;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (func3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = b31;
            3'b101:  taken = !b31;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        unique case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_a  = SRC_A_PC;
                ctrl.alu_src_b  = SRC_B_FOUR;
                ctrl.result_src = RES_ALU;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // ALUOut captures OldPC+imm as the branch/jal target
                ctrl.alu_src_a = SRC_A_OLDPC;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.imm_src   = (op == OP_BRANCH) ? IMM_B :
                                 (op == OP_JAL)    ? IMM_J : IMM_I;
                if (illegal) begin
                    ctrl.illegal_op = 1'b1;
                    ctrl.instr_done = 1'b1;
                    state_d         = ST_FETCH;
                end else begin
                    case (op)
                        OP_LOAD, OP_STORE: state_d = ST_MEM_ADR;
                        OP_RTYPE:  state_d = ST_EXEC_R;
                        OP_ITYPE:  state_d = ST_EXEC_I;
                        OP_BRANCH: state_d = ST_BRANCH;
                        OP_JAL:    state_d = ST_JAL;
                        OP_JALR:   state_d = ST_JALR;
                        OP_LUI:    state_d = ST_LUI;
                        default:   state_d = ST_FETCH;
                    endcase
                end
            end
            ST_MEM_ADR: begin
                ctrl.alu_src_a = SRC_A_REG;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
                state_d = (op == OP_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                ctrl.adr_src = 1'b1;
                ctrl.mem_req = 1'b1;
                if (mem_ready) state_d = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                ctrl.adr_src    = 1'b1;
                ctrl.mem_req    = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready;
                if (mem_ready) state_d = ST_FETCH;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a   = SRC_A_REG;
                ctrl.alu_src_b   = SRC_B_REG;
                ctrl.alu_control = dec_alu;
                state_d          = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a   = SRC_A_REG;
                ctrl.alu_src_b   = SRC_B_IMM;
                ctrl.imm_src     = IMM_I;
                ctrl.alu_control = dec_alu;
                state_d          = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = ST_FETCH;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a   = SRC_A_REG;
                ctrl.alu_src_b   = SRC_B_REG;
                ctrl.alu_control = ALU_SUB;
                ctrl.result_src  = RES_ALUOUT;
                ctrl.pc_write    = taken;
                ctrl.instr_done  = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_JAL: begin
                // PC takes the DECODE target while the ALU forms the link
                ctrl.alu_src_a  = SRC_A_OLDPC;
                ctrl.alu_src_b  = SRC_B_FOUR;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
                state_d         = ST_ALU_WB;
            end
            ST_JALR: begin
                ctrl.alu_src_a  = SRC_A_REG;
                ctrl.alu_src_b  = SRC_B_IMM;
                ctrl.result_src = RES_ALU;
                ctrl.pc_write   = 1'b1;
                state_d         = ST_JALR_LINK;
            end
            ST_JALR_LINK: begin
                ctrl.alu_src_a = SRC_A_OLDPC;
                ctrl.alu_src_b = SRC_B_FOUR;
                state_d        = ST_ALU_WB;
            end
            ST_LUI: begin
                ctrl.alu_src_a = SRC_A_ZERO;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.imm_src   = IMM_U;
                state_d        = ST_ALU_WB;
            end
            default: state_d = ST_RESET;
        endcase
        // reset overrides everything, abandoning any pending request
        if (rst) begin
            ctrl    = '0;
            state_d = ST_RESET;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RESET;
        else     state_q <= state_d;
    end

    assign mem_req     = ctrl.mem_req;
    assign mem_write   = ctrl.mem_write;
    assign adr_src     = ctrl.adr_src;
    assign ir_write    = ctrl.ir_write;
    assign pc_write    = ctrl.pc_write;
    assign reg_write   = ctrl.reg_write;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign alu_control = ctrl.alu_control;
    assign imm_src     = ctrl.imm_src;
    assign result_src  = ctrl.result_src;
    assign illegal_op  = ctrl.illegal_op;
    assign instr_done  = ctrl.instr_done;

endmodule

// File: tb/tb_risc_v_multicycle_controller.sv
// Bench for the multi-cycle controller: per-instruction expected
// control traces built from the instruction rules, replayed cycle by cycle.
module tb_risc_v_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] func3 = 3'd0;
    logic       func7 = 1'b0;
    logic       zero = 1'b0;
    logic       b31 = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control, imm_src;
    logic       illegal_op, instr_done;
    logic [19:0] obs;

    typedef struct packed {
        logic        r;
        logic        rdy;
        logic        z;
        logic        n;
        logic [6:0]  o;
        logic [2:0]  f3;
        logic        f7;
        logic [19:0] e;
    } cyc_t;

    cyc_t       q[$];
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;
    int n_chk = 0;
    int n_err = 0;
    int exp_done = 0;
    int obs_done = 0;

    risc_v_multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .b31(b31), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .imm_src(imm_src),
        .result_src(result_src), .illegal_op(illegal_op),
        .instr_done(instr_done)
    );

    assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, alu_control, imm_src, result_src,
                  illegal_op, instr_done};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [19:0] cw(
        input logic req, wr, adr, irw, pcw, rw,
        input logic [1:0] sa, sb,
        input logic [2:0] alu, imm,
        input logic [1:0] res,
        input logic ill, done);
        return {req, wr, adr, irw, pcw, rw, sa, sb, alu, imm, res, ill, done};
    endfunction

    task automatic push(input logic r, rdy, z, n, input logic [19:0] e);
        cyc_t c;
        c.r = r; c.rdy = rdy; c.z = z; c.n = n;
        c.o = cur_op; c.f3 = cur_f3; c.f7 = cur_f7; c.e = e;
        q.push_back(c);
    endtask

    task automatic push_wb();
        push(1'b0, rb(), rb(), rb(),
             cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00,
                3'b000, 3'b000, 2'b00, 1'b0, 1'b1));
    endtask

    // Expected control trace of one instruction. zs/ns < 0 mean random flags.
    task automatic gen(input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input int fw, input int mw,
                       input int zs, input int ns, input bit abort);
        logic ld, st, r, i, br, jl, jr, lu, ok, aok, z, n, tk;
        logic [2:0] a, im;
        cur_op = o; cur_f3 = f3; cur_f7 = f7;
        ld = (o == 7'b0000011); st = (o == 7'b0100011);
        r  = (o == 7'b0110011); i  = (o == 7'b0010011);
        br = (o == 7'b1100011); jl = (o == 7'b1101111);
        jr = (o == 7'b1100111); lu = (o == 7'b0110111);
        aok = 1'b1;
        a = 3'b000;
        case (f3)
            3'b000:  a = (r && f7) ? 3'b001 : 3'b000;
            3'b111:  a = 3'b010;
            3'b110:  a = 3'b011;
            3'b100:  a = 3'b100;
            3'b010:  a = 3'b101;
            3'b011:  a = 3'b110;
            default: aok = 1'b0;
        endcase
        ok = (ld | st | r | i | br | jl | jr | lu)
             && !((r | i) && !aok)
             && !(br && !(f3 inside {3'b000, 3'b001, 3'b100, 3'b101}))
             && !(jr && f3 != 3'b000);
        for (int k = 0; k < fw; k++)
            push(1'b0, 1'b0, rb(), rb(),
                 cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10,
                    3'b000, 3'b000, 2'b10, 1'b0, 1'b0));
        push(1'b0, 1'b1, rb(), rb(),
             cw(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10,
                3'b000, 3'b000, 2'b10, 1'b0, 1'b0));
        im = br ? 3'b010 : (jl ? 3'b011 : 3'b000);
        push(1'b0, rb(), rb(), rb(),
             cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01,
                3'b000, im, 2'b00, !ok, !ok));
        if (!ok) return;
        if (ld || st) begin
            push(1'b0, rb(), rb(), rb(),
                 cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01,
                    3'b000, st ? 3'b001 : 3'b000, 2'b00, 1'b0, 1'b0));
            for (int k = 0; k < mw; k++) begin
                push(1'b0, 1'b0, rb(), rb(),
                     cw(1'b1, st, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                        3'b000, 3'b000, 2'b00, 1'b0, 1'b0));
                if (abort) begin
                    push(1'b1, 1'b0, rb(), rb(), 20'd0);
                    push(1'b0, rb(), rb(), rb(), 20'd0);
                    return;
                end
            end
            push(1'b0, 1'b1, rb(), rb(),
                 cw(1'b1, st, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                    3'b000, 3'b000, 2'b00, 1'b0, st));
            if (ld)
                push(1'b0, rb(), rb(), rb(),
                     cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00,
                        3'b000, 3'b000, 2'b01, 1'b0, 1'b1));
        end else if (r || i) begin
            push(1'b0, rb(), rb(), rb(),
                 cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10,
                    r ? 2'b00 : 2'b01, a, 3'b000, 2'b00, 1'b0, 1'b0));
            push_wb();
        end else if (br) begin
            z = (zs < 0) ? rb() : zs[0];
            n = (ns < 0) ? rb() : ns[0];
            tk = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z :
                 (f3 == 3'b100) ? n : !n;
            push(1'b0, rb(), z, n,
                 cw(1'b0, 1'b0, 1'b0, 1'b0, tk, 1'b0, 2'b10, 2'b00,
                    3'b001, 3'b000, 2'b00, 1'b0, 1'b1));
        end else if (jl) begin
            push(1'b0, rb(), rb(), rb(),
                 cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10,
                    3'b000, 3'b000, 2'b00, 1'b0, 1'b0));
            push_wb();
        end else if (jr) begin
            push(1'b0, rb(), rb(), rb(),
                 cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01,
                    3'b000, 3'b000, 2'b10, 1'b0, 1'b0));
            push(1'b0, rb(), rb(), rb(),
                 cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10,
                    3'b000, 3'b000, 2'b00, 1'b0, 1'b0));
            push_wb();
        end else begin
            push(1'b0, rb(), rb(), rb(),
                 cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01,
                    3'b000, 3'b100, 2'b00, 1'b0, 1'b0));
            push_wb();
        end
    endtask

    // Replays the queued trace; exp_len > 0 also checks the cycle of instr_done.
    task automatic run_q(input string tag, input int exp_len);
        cyc_t c;
        int   cyc = 0;
        int   done_at = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            cyc++;
            @(posedge clk);
            #1;
            rst = c.r; mem_ready = c.rdy; zero = c.z; b31 = c.n;
            op = c.o; func3 = c.f3; func7 = c.f7;
            @(negedge clk);
            chk($sformatf("%s_c%0d", tag, cyc), 32'(obs), 32'(c.e));
            if (instr_done && done_at == 0) done_at = cyc;
            if (instr_done) obs_done++;
            if (c.e[0]) exp_done++;
        end
        if (exp_len > 0)
            chk({tag, "_len"}, 32'(done_at), 32'(exp_len));
    endtask

    logic [6:0] ops [8];

    initial begin
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        cur_op = 7'd0; cur_f3 = 3'd0; cur_f7 = 1'b0;
        for (int k = 0; k < 3; k++) push(1'b1, rb(), rb(), rb(), 20'd0);
        push(1'b0, rb(), rb(), rb(), 20'd0);
        run_q("reset", 0);

        gen(7'b0110011, 3'b000, 1'b0, 0, 0, -1, -1, 1'b0);
        run_q("add", 4);
        gen(7'b0000011, 3'b010, 1'b0, 0, 2, -1, -1, 1'b0);
        run_q("lw_wait", 7);
        gen(7'b1100011, 3'b000, 1'b0, 0, 0, 1, -1, 1'b0);
        run_q("beq_z1", 3);
        gen(7'b1100011, 3'b001, 1'b0, 0, 0, 1, -1, 1'b0);
        run_q("bne_z1", 3);
        for (int nv = 1; nv >= 0; nv--) begin
            gen(7'b1100011, 3'b100, 1'b0, 0, 0, -1, nv, 1'b0);
            run_q($sformatf("blt_n%0d", nv), 3);
            gen(7'b1100011, 3'b101, 1'b0, 0, 0, -1, nv, 1'b0);
            run_q($sformatf("bge_n%0d", nv), 3);
        end
        gen(7'b1100111, 3'b000, 1'b0, 0, 0, -1, -1, 1'b0);
        run_q("jalr", 5);
        gen(7'b1100111, 3'b001, 1'b0, 0, 0, -1, -1, 1'b0);
        run_q("jalr_ill", 2);
        gen(7'b0100011, 3'b010, 1'b0, 0, 2, -1, -1, 1'b1);
        run_q("sw_rst", 0);
        gen(7'b0110111, 3'b000, 1'b0, 1, 0, -1, -1, 1'b0);
        run_q("lui_after_rst", 5);

        for (int t = 0; t < 250; t++) begin
            int idx;
            logic [6:0] o;
            idx = $urandom_range(0, 8);
            o = (idx == 8) ? 7'($urandom) : ops[idx];
            gen(o, 3'($urandom), 1'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 2), -1, -1, 1'b0);
            run_q($sformatf("rnd%0d", t), 0);
        end

        chk("done_count", 32'(obs_done), 32'(exp_done));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
